alu_iter: RTL
=============

# alu_iter

Parametrised successor to the single-cycle integer ALU. It adds a valid/ready handshake, a registered result, and iterative RV32M multiply/divide. It executes the RV32I ALU operations with a fixed one-cycle latency, and MUL/DIV/REM-family operations with a radix-2 shift-add/restoring-divide datapath over XLEN cycles. It sits in the execute stage, and the pipeline stalls on `o_ready`/`o_valid`.

## Interface
- `XLEN`, default 32: operand/result width; must be ≥ 8 and a power of two.
- `SHW`, default $clog2(XLEN): shift-amount width. Derived; do not override.
- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  reset; asynchronous assert, active-low.
- `i_valid`  in  1  request valid.
- `o_ready`  out  1  block can accept a request this cycle.
- `i_op`  in  4  operation code: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU. `i_rem` selects remainder for 14/15.
- `i_rem`  in  1  with op 14 returns REM, with op 15 returns REMU; ignored for all other ops.
- `i_operand_a`  in  XLEN  operand a (rs1 / dividend / multiplicand).
- `i_operand_b`  in  XLEN  operand b (rs2 / divisor / multiplier).
- `i_flush`  in  1  synchronous abort of any in-flight or pending operation.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  consumer accepts the result.
- `o_result`  out  XLEN  result, registered.

## Operation
- FSM states:
  - IDLE: `o_ready`=1, `o_valid`=0.
  - BUSY: iterating; `o_ready`=0, `o_valid`=0.
  - DONE: `o_valid`=1; `o_ready`=`i_ready`, which allows back-to-back requests.
- Accept occurs when `i_valid` && `o_ready`. Operands, op and `i_rem` are captured on accept.
- Ops 0–9, and the div/rem special cases below, compute combinationally from the inputs. On accept they go directly to DONE with `o_result` loaded.
- Shifts use `operand_b[SHW-1:0]` only. SRA replicates `operand_a[XLEN-1]`.
- SLT/SLTU return 1 or 0, zero-extended.
- SLT compares signed via XLEN+1-bit sign-extended subtraction. SLTU compares via zero-extended subtraction.
- MUL family:
  - Operands are converted to magnitudes according to signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - The unit performs XLEN shift-add steps into a 2·XLEN accumulator, then negates the product if the signs differ.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- DIV family:
  - Operands are converted to magnitudes (unsigned ops unchanged), then XLEN restoring steps run.
  - Quotient sign is sign(a)^sign(b). Remainder takes the sign of the dividend.
- Special cases, each resolved in 1 cycle without entering BUSY:
  - Divide by zero: quotient = all-ones, remainder = a.
  - Signed overflow (a = MIN, b = −1): quotient = MIN, remainder = 0.
- In DONE, `o_result` and `o_valid` hold stable until `i_ready`.
  - With `i_ready` and no new accept, the FSM goes to IDLE.
  - With `i_ready` and a new accept, it re-enters DONE or BUSY directly.
- `i_flush` has priority over everything. Next state is IDLE, `o_valid` is 0, the iteration counter is cleared, and a same-cycle request is not accepted. `o_result` keeps its value.

## Timing
- Reset (`i_rst_n`=0, asynchronous): state IDLE, `o_valid`=0, `o_result`=0, counter=0. `o_ready` is 1 while in reset. Reset mid-iteration discards the operation; no result is produced.
- Latency for ops 0–9 and the div/rem special cases: accept at edge T gives `o_valid` high after edge T, so the result is available in cycle T+1.
- Latency for MUL and DIV ops: accept at T, BUSY during cycles T+1…T+XLEN (counter XLEN−1 down to 0), `o_valid` from cycle T+XLEN+1. That is XLEN+1 cycles accept-to-valid.
- Throughput:
  - One single-cycle op per cycle when `i_ready` is held high.
  - One MUL/DIV op per XLEN+1 cycles.
- Backpressure: `i_ready`=0 in DONE holds the result indefinitely and keeps `o_ready`=0.
- `i_valid` is sampled only when `o_ready`=1. The requester holds the request until it is accepted; changing it before acceptance has no effect on the block.

## Test plan
- Reset and single-cycle ops:
  - Assert `i_rst_n`=0 mid-BUSY → `o_valid`=0, `o_result`=0 immediately.
  - ADD 0xFFFFFFFF+1 → 0x00000000 at T+1.
  - SRA 0x80000000 by b=0x21 → 0xC0000000 (shift 1).
- Compares: SLT a=0xFFFFFFFF, b=1 → 1. SLTU with the same operands → 0. SLT a=0x80000000, b=0x7FFFFFFF → 1.
- Multiply, each with `o_valid` exactly at T+33:
  - MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divide, each at T+33:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Divide special cases, each in 1 cycle:
  - DIV x/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Handshake, flush and parameterisation:
  - Hold `i_ready`=0 for 5 cycles after DONE → result stable and `o_ready`=0.
  - Back-to-back ADDs with `i_ready`=1 → one result per cycle.
  - `i_flush` at BUSY cycle 10 → IDLE next cycle, no `o_valid`.
  - Rerun the ADD/MUL/DIV vectors with XLEN=16 → MUL/DIV latency 17.

Source files
------------

// File: rtl/alu_iter.sv
// alu_iter: execute-stage integer ALU with a valid/ready handshake and a
// registered result. RV32I ALU ops and divide special cases finish in one
// cycle. MUL/DIV/REM families iterate radix-2 over XLEN cycles.
//
// Handshake: a request is accepted on a rising edge where i_valid && o_ready
// and i_flush is low. A result is offered while o_valid is high and is
// consumed on a rising edge where i_ready is high. o_result and o_valid hold
// until then.
module alu_iter #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_op,
  input  logic            i_rem,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [1:0]      o_dbg_state
);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_XOR = 4'd2,  OP_OR = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_SLL = 4'd5,  OP_SRL = 4'd6,  OP_SRA = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8,  OP_SLTU = 4'd9, OP_MUL = 4'd10, OP_MULH = 4'd11;
  localparam logic [3:0] OP_MULHSU = 4'd12, OP_MULHU = 4'd13, OP_DIV = 4'd14, OP_DIVU = 4'd15;

  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW-1:0]  CNT_INIT = SHW'(XLEN-1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;     // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]     opb_q, opb_d;     // multiplicand or divisor magnitude
  logic [3:0]          op_q, op_d;
  logic                rem_q, rem_d;
  logic                neg_q, neg_d;     // product/quotient must be negated
  logic                rneg_q, rneg_d;   // remainder must be negated (dividend sign)
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept;
  logic [SHW-1:0]      shamt;
  logic [XLEN:0]       slt_diff, sltu_diff;
  logic                is_mul, is_div, a_signed, b_signed, a_neg, b_neg;
  logic                div_zero, div_ovf, iter_start;
  logic [XLEN-1:0]     a_mag, b_mag, imm_res;
  logic                is_mul_q;
  logic [XLEN:0]       add_sum, rem_try;
  logic [2*XLEN-1:0]   mul_next, div_next, step_next, prod;
  logic [XLEN-1:0]     quot, remd, fin_res;

  assign o_valid     = (state_q == S_DONE);
  assign o_result    = result_q;
  assign o_dbg_state = state_q;

  // Decode the incoming request and compute single-cycle results.
  always_comb begin
    shamt     = i_operand_b[SHW-1:0];
    slt_diff  = {i_operand_a[XLEN-1], i_operand_a} - {i_operand_b[XLEN-1], i_operand_b};
    sltu_diff = {1'b0, i_operand_a} - {1'b0, i_operand_b};
    is_mul    = (i_op >= OP_MUL) && (i_op <= OP_MULHU);
    is_div    = (i_op >= OP_DIV);
    // MUL low bits do not depend on signedness; treat it as signed x signed.
    a_signed  = (i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV);
    b_signed  = (i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_DIV);
    a_neg     = a_signed && i_operand_a[XLEN-1];
    b_neg     = b_signed && i_operand_b[XLEN-1];
    a_mag     = a_neg ? (~i_operand_a + 1'b1) : i_operand_a;
    b_mag     = b_neg ? (~i_operand_b + 1'b1) : i_operand_b;
    div_zero  = is_div && (i_operand_b == '0);
    div_ovf   = (i_op == OP_DIV) && (i_operand_a == MIN_VAL) && (i_operand_b == '1);
    iter_start = is_mul || (is_div && !div_zero && !div_ovf);
    imm_res   = '0;
    case (i_op)
      OP_ADD:  imm_res = i_operand_a + i_operand_b;
      OP_SUB:  imm_res = i_operand_a - i_operand_b;
      OP_XOR:  imm_res = i_operand_a ^ i_operand_b;
      OP_OR:   imm_res = i_operand_a | i_operand_b;
      OP_AND:  imm_res = i_operand_a & i_operand_b;
      OP_SLL:  imm_res = i_operand_a << shamt;
      OP_SRL:  imm_res = i_operand_a >> shamt;
      OP_SRA:  imm_res = $unsigned($signed(i_operand_a) >>> shamt);
      OP_SLT:  imm_res = {{(XLEN-1){1'b0}}, slt_diff[XLEN]};
      OP_SLTU: imm_res = {{(XLEN-1){1'b0}}, sltu_diff[XLEN]};
      default: begin
        if (div_zero)     imm_res = i_rem ? i_operand_a : '1;
        else if (div_ovf) imm_res = i_rem ? '0 : MIN_VAL;
      end
    endcase
  end

  // One radix-2 iteration step and the sign-corrected final result.
  always_comb begin
    is_mul_q  = (op_q >= OP_MUL) && (op_q <= OP_MULHU);
    add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
    mul_next  = {add_sum, acc_q[XLEN-1:1]};
    rem_try   = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    div_next  = rem_try[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                              : {rem_try[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step_next = is_mul_q ? mul_next : div_next;
    prod      = neg_q ? (~step_next + 1'b1) : step_next;
    quot      = neg_q ? (~step_next[XLEN-1:0] + 1'b1) : step_next[XLEN-1:0];
    remd      = rneg_q ? (~step_next[2*XLEN-1:XLEN] + 1'b1) : step_next[2*XLEN-1:XLEN];
    if (op_q == OP_MUL) fin_res = prod[XLEN-1:0];
    else if (is_mul_q)  fin_res = prod[2*XLEN-1:XLEN];
    else                fin_res = rem_q ? remd : quot;
  end

  // FSM next state, handshake outputs and datapath next values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    op_d     = op_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    o_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && i_ready);
    accept   = i_valid && o_ready && !i_flush;
    if (i_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_BUSY: begin
          acc_d = step_next;
          if (cnt_q == '0) begin
            result_d = fin_res;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_DONE:  if (i_ready) state_d = S_IDLE;
        default: ;
      endcase
      if (accept) begin
        op_d  = i_op;
        rem_d = i_rem;
        if (iter_start) begin
          state_d = S_BUSY;
          cnt_d   = CNT_INIT;
          acc_d   = {{XLEN{1'b0}}, (is_mul ? b_mag : a_mag)};
          opb_d   = is_mul ? a_mag : b_mag;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
        end else begin
          state_d  = S_DONE;
          result_d = imm_res;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      rem_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

endmodule
